timer_countdown_ctrl: RTL and testbench

//  MM:SS countdown-timer controller. Holds the minute/second counters, sequences start/pause/load,
//  and time-multiplexes ONE shared bin2bcd converter to produce four registered BCD display digits.

---
 rtl/timer_pkg.sv | 29 ++
 rtl/bin2bcd.sv | 17 +
 rtl/timer_countdown_ctrl.sv | 161 ++++++++++++++++
 tb/tb_timer_countdown_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module  : timer_pkg                                               |
// | Brief   : Shared types and constants for the MM:SS countdown timer |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CONV_IDLE = 2'd0,
        CONV_SEC  = 2'd1,
        CONV_MIN  = 2'd2
    } conv_t;

    localparam logic [5:0] c_MAX_VAL = 6'd59;

    function automatic logic [5:0] sat_val(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module  : bin2bcd                                                 |
// | Brief   : 6-bit binary to two-digit BCD, purely combinational     |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
module bin2bcd (
    input  logic [5:0] valoare_bin,
    output logic [3:0] BCD1,
    output logic [3:0] BCD0
);

    assign BCD1 = 4'(valoare_bin / 6'd10);
    assign BCD0 = 4'(valoare_bin % 6'd10);

endmodule
`default_nettype wire

// File: rtl/timer_countdown_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module  : timer_countdown_ctrl                                    |
// | Brief   : MM:SS countdown controller with shared BCD conversion   |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
module timer_countdown_ctrl
    import timer_pkg::*;
#(
    parameter int         CLK_PER_SEC = 50_000_000,
    parameter logic [5:0] MAX_VAL     = c_MAX_VAL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    output logic [3:0] min_bcd1,
    output logic [3:0] min_bcd0,
    output logic [3:0] sec_bcd1,
    output logic [3:0] sec_bcd0,
    output logic       digits_valid,
    output logic       running,
    output logic       done
);

    localparam int            PW         = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] c_PRE_LAST = PW'(CLK_PER_SEC - 1);

    state_t        r_state;
    conv_t         r_conv;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic [PW-1:0] r_pre;

    logic          w_tick;
    logic          w_load_ok;
    logic          w_write;
    logic          w_nonzero;
    logic [5:0]    w_min_ld;
    logic [5:0]    w_sec_ld;
    logic [5:0]    w_bin;
    logic [3:0]    w_bcd1;
    logic [3:0]    w_bcd0;

    // stop on the terminal prescaler cycle suppresses the tick entirely
    assign w_tick    = (r_state == RUN) && !stop && (r_pre == c_PRE_LAST);
    assign w_load_ok = load && (r_state != RUN);
    assign w_write   = w_tick || w_load_ok;
    assign w_nonzero = (r_min != 6'd0) || (r_sec != 6'd0);
    assign w_min_ld  = sat_val(min_in, MAX_VAL);
    assign w_sec_ld  = sat_val(sec_in, MAX_VAL);
    assign w_bin     = (r_conv == CONV_MIN) ? r_min : r_sec;

    bin2bcd u_bin2bcd (
        .valoare_bin (w_bin),
        .BCD1        (w_bcd1),
        .BCD0        (w_bcd0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_min   <= 6'd0;
            r_sec   <= 6'd0;
            r_pre   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_min <= w_min_ld;
                        r_sec <= w_sec_ld;
                    end else if (start && w_nonzero) begin
                        r_state <= RUN;
                        running <= 1'b1;
                        r_pre   <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= PAUSE;
                        running <= 1'b0;
                    end else if (w_tick) begin
                        r_pre <= '0;
                        if (r_sec != 6'd0) begin
                            r_sec <= r_sec - 6'd1;
                        end else if (r_min != 6'd0) begin
                            r_sec <= MAX_VAL;
                            r_min <= r_min - 6'd1;
                        end
                        if (r_min == 6'd0 && r_sec <= 6'd1) begin
                            r_state <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        r_pre <= r_pre + PW'(1);
                    end
                end
                PAUSE: begin
                    if (load) begin
                        r_min <= w_min_ld;
                        r_sec <= w_sec_ld;
                        r_pre <= '0;
                    end else if (start && !stop && w_nonzero) begin
                        r_state <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    if (load) begin
                        r_min   <= w_min_ld;
                        r_sec   <= w_sec_ld;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // A fresh counter write always restarts the seconds-then-minutes pass
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conv       <= CONV_IDLE;
            min_bcd1     <= 4'd0;
            min_bcd0     <= 4'd0;
            sec_bcd1     <= 4'd0;
            sec_bcd0     <= 4'd0;
            digits_valid <= 1'b1;
        end else if (w_write) begin
            r_conv       <= CONV_SEC;
            digits_valid <= 1'b0;
        end else begin
            case (r_conv)
                CONV_SEC: begin
                    sec_bcd1 <= w_bcd1;
                    sec_bcd0 <= w_bcd0;
                    r_conv   <= CONV_MIN;
                end
                CONV_MIN: begin
                    min_bcd1     <= w_bcd1;
                    min_bcd0     <= w_bcd0;
                    r_conv       <= CONV_IDLE;
                    digits_valid <= 1'b1;
                end
                default: r_conv <= CONV_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_countdown_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | Module  : tb_timer_countdown_ctrl                                 |
// | Brief   : Scoreboard bench with a time-remaining reference model  |
// | Revision: 1.0                                                     |
// +-------------------------------------------------------------------+
module tb_timer_countdown_ctrl;

    localparam int CPS     = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       load = 1'b0;
    logic [5:0] min_in = 6'd0;
    logic [5:0] sec_in = 6'd0;
    logic [3:0] min_bcd1, min_bcd0, sec_bcd1, sec_bcd0;
    logic       digits_valid, running, done;

    always #5 clk = ~clk;

    timer_countdown_ctrl #(.CLK_PER_SEC(CPS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .load         (load),
        .min_in       (min_in),
        .sec_in       (sec_in),
        .min_bcd1     (min_bcd1),
        .min_bcd0     (min_bcd0),
        .sec_bcd1     (sec_bcd1),
        .sec_bcd0     (sec_bcd0),
        .digits_valid (digits_valid),
        .running      (running),
        .done         (done)
    );

    typedef struct packed {
        logic running;
        logic done;
        logic valid;
        logic pop;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] dig_q[$];
    int          vectors = 0;
    int          errors  = 0;
    bit          finished = 1'b0;

    // Reference model: time remaining in whole seconds plus a cycle count into the second
    int m_mode  = M_IDLE;
    int m_total = 0;
    int m_pre   = 0;
    int m_since = 2;

    function automatic int sat(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    function automatic logic [15:0] digits_of(input int t);
        int mm, ss;
        mm = t / 60;
        ss = t % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic step(input bit r, input bit st, input bit sp, input bit ld,
                        input int mi, input int si);
        exp_t e;
        bit   wr;
        bit   dn;
        @(negedge clk);
        rst = r; start = st; stop = sp; load = ld;
        min_in = 6'(mi); sec_in = 6'(si);
        wr = 1'b0;
        dn = 1'b0;
        e  = '0;
        if (r) begin
            m_mode = M_IDLE; m_total = 0; m_pre = 0; m_since = 2;
            dig_q.delete();
            dig_q.push_back(16'h0000);
            e.valid = 1'b1;
            e.pop   = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (ld) begin
                        m_total = sat(mi) * 60 + sat(si); wr = 1'b1;
                    end else if (st && m_total != 0) begin
                        m_mode = M_RUN; m_pre = 0;
                    end
                end
                M_RUN: begin
                    if (sp) m_mode = M_PAUSE;
                    else if (m_pre == CPS - 1) begin
                        m_pre = 0; m_total--; wr = 1'b1;
                        if (m_total == 0) begin m_mode = M_DONE; dn = 1'b1; end
                    end else m_pre++;
                end
                M_PAUSE: begin
                    if (ld) begin
                        m_total = sat(mi) * 60 + sat(si); m_pre = 0; wr = 1'b1;
                    end else if (st && !sp && m_total != 0) m_mode = M_RUN;
                end
                default: begin
                    if (ld) begin
                        m_total = sat(mi) * 60 + sat(si); wr = 1'b1; m_mode = M_IDLE;
                    end
                end
            endcase
            if (wr) begin
                if (m_since < 2) void'(dig_q.pop_back());
                dig_q.push_back(digits_of(m_total));
                m_since = 0;
            end else if (m_since < 2) begin
                m_since++;
                if (m_since == 2) e.pop = 1'b1;
            end
            e.running = (m_mode == M_RUN);
            e.done    = dn;
            e.valid   = (m_since >= 2);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_until_tick();
        for (int i = 0; i < CPS + 2 && !(m_mode == M_RUN && m_pre == CPS - 1); i++)
            step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    // Monitor: one expectation per clock edge, digits popped when a conversion completes
    initial begin
        exp_t        e;
        logic [15:0] cur;
        cur = 16'h0000;
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (finished) break;
                errors++;
                $display("FAIL queue_underrun at %0t", $time);
                continue;
            end
            e = exp_q.pop_front();
            chk("running", int'(running), int'(e.running));
            chk("done", int'(done), int'(e.done));
            chk("digits_valid", int'(digits_valid), int'(e.valid));
            if (e.pop) begin
                if (dig_q.size() == 0) begin
                    errors++;
                    $display("FAIL digit_queue_empty at %0t", $time);
                end else begin
                    cur = dig_q.pop_front();
                end
            end
            if (e.valid && digits_valid)
                chk("digits", int'({min_bcd1, min_bcd0, sec_bcd1, sec_bcd0}), int'(cur));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 5);
        idle(3);
        // 00:03 counts down to DONE; start while DONE is ignored
        step(0, 0, 0, 1, 0, 3);
        idle(2);
        step(0, 1, 0, 0, 0, 0);
        idle(20);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(7);
        // stop coinciding with the tick, then resume after 10 cycles
        run_until_tick();
        step(0, 0, 1, 0, 0, 0);
        idle(10);
        step(0, 1, 0, 0, 0, 0);
        idle(8);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 1, 63, 60);
        idle(3);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(3);
        // reset landing while a tick conversion is in flight
        step(0, 0, 0, 1, 0, 9);
        step(0, 1, 0, 0, 0, 0);
        run_until_tick();
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 14) == 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 8)));
        end
        idle(2);
        finished = 1'b1;
    end

endmodule
`default_nettype wire
